// File: rtl/sdram_responder.sv
// sdram_responder: chip-side model of an MT48LC16M16-style SDRAM.
// Decodes commands, tracks mode and per-bank rows, serves single-word
// writes and CL/BL-timed read bursts from an internal word array, and
// latches the first protocol violation it sees.
//
// Read burst engine states:
//   state    | meaning
//   RD_IDLE  | no burst word is driven after the current one
//   RD_BURST | a burst is in progress; r_b_idx is the next word to drive
module sdram_responder #(
  parameter int MEM_AW = 14,
  parameter int T_RCD  = 2
) (
  input  logic        clk_96,
  input  logic        init,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  // tRCD down-counter: loaded with T_RCD-1 on ACTIVE, access legal at zero.
  localparam int RCW = (T_RCD > 2) ? $clog2(T_RCD) : 1;
  localparam logic [RCW-1:0] RCD_LOAD = RCW'(T_RCD - 1);

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  logic [3:0]     w_cmd;
  logic           w_is_act, w_is_rd, w_is_wr, w_is_pre, w_is_ref, w_is_lmr, w_is_bst;
  logic           w_open_sel, w_rd_ok, w_wr_ok, w_kill, w_mode_bad;
  logic [23:0]    w_cmd_addr;
  logic [MEM_AW-1:0] w_wr_addr, w_rd_addr;
  logic [2:0]     w_err;

  logic [15:0]    r_mem [2**MEM_AW];
  logic [3:0]     r_open;
  logic [12:0]    r_row [4];
  logic [RCW-1:0] r_rcd [4];
  logic           r_cl3, r_ilv;
  logic [1:0]     r_bl;
  logic           r_err;
  logic [2:0]     r_code;
  logic [15:0]    r_dq;
  logic           r_oe;

  // Pending reads: p1 starts its burst at the next edge, p2 one edge later.
  logic           r_p1_v, r_p1_ilv, r_p1_ap, r_p2_v, r_p2_ilv, r_p2_ap;
  logic [23:0]    r_p1_addr, r_p2_addr;
  logic [1:0]     r_p1_bl, r_p2_bl;

  // Burst in progress.
  logic [23:0]    r_b_addr;
  logic [1:0]     r_b_bl;
  logic           r_b_ilv, r_b_ap;
  logic [2:0]     r_b_idx;

  rd_state_t      r_state, w_state_nx;
  logic           w_drive, w_from_pend, w_last;
  logic [23:0]    w_sel_addr;
  logic [1:0]     w_sel_bl;
  logic           w_sel_ilv, w_sel_ap;
  logic [2:0]     w_idx, w_b_last_idx;
  logic [8:0]     w_mask, w_col_base, w_col_lo, w_col;

  assign w_cmd      = {sd_cs, sd_ras, sd_cas, sd_we};
  assign w_is_act   = (w_cmd == 4'b0011);
  assign w_is_rd    = (w_cmd == 4'b0101);
  assign w_is_wr    = (w_cmd == 4'b0100);
  assign w_is_pre   = (w_cmd == 4'b0010);
  assign w_is_ref   = (w_cmd == 4'b0001);
  assign w_is_lmr   = (w_cmd == 4'b0000);
  assign w_is_bst   = (w_cmd == 4'b0110);

  // Accesses to an idle bank are flagged and otherwise ignored.
  assign w_open_sel = r_open[sd_ba];
  assign w_rd_ok    = w_is_rd & w_open_sel;
  assign w_wr_ok    = w_is_wr & w_open_sel;
  assign w_kill     = w_wr_ok | w_is_bst;
  assign w_mode_bad = !((sd_addr[6:4] == 3'd2) || (sd_addr[6:4] == 3'd3)) || sd_addr[2];

  assign w_cmd_addr = {sd_ba, r_row[sd_ba], sd_addr[8:0]};
  assign w_wr_addr  = MEM_AW'(w_cmd_addr);

  // Burst word addressing: keep the column above the burst, wrap or XOR below.
  assign w_sel_addr   = w_from_pend ? r_p1_addr : r_b_addr;
  assign w_sel_bl     = w_from_pend ? r_p1_bl   : r_b_bl;
  assign w_sel_ilv    = w_from_pend ? r_p1_ilv  : r_b_ilv;
  assign w_sel_ap     = w_from_pend ? r_p1_ap   : r_b_ap;
  assign w_idx        = w_from_pend ? 3'd0      : r_b_idx;
  assign w_b_last_idx = 3'((4'd1 << r_b_bl) - 4'd1);
  assign w_mask       = 9'((10'd1 << w_sel_bl) - 10'd1);
  assign w_col_base   = w_sel_addr[8:0];
  assign w_col_lo     = w_sel_ilv ? (w_col_base ^ {6'd0, w_idx}) : (w_col_base + {6'd0, w_idx});
  assign w_col        = (w_col_base & ~w_mask) | (w_col_lo & w_mask);
  assign w_rd_addr    = MEM_AW'({w_sel_addr[23:9], w_col});

  assign sd_dq_out = r_dq;
  assign sd_dq_oe  = r_oe;
  assign proto_err = r_err;
  assign err_code  = r_code;

  // Violation code of the command sampled this edge (0 = none).
  always_comb begin
    w_err = 3'd0;
    if (w_is_act && w_open_sel)                       w_err = 3'd1;
    else if ((w_is_rd || w_is_wr) && !w_open_sel)     w_err = 3'd2;
    else if ((w_is_rd || w_is_wr) && r_rcd[sd_ba] != '0) w_err = 3'd3;
    else if ((w_is_lmr || w_is_ref) && (|r_open))     w_err = 3'd4;
    else if (w_is_lmr && w_mode_bad)                  w_err = 3'd5;
  end

  // Burst engine next state: a due pending read preempts the running burst.
  always_comb begin
    w_state_nx  = r_state;
    w_drive     = 1'b0;
    w_from_pend = 1'b0;
    w_last      = 1'b0;
    if (w_kill) begin
      w_state_nx = RD_IDLE;
    end else if (r_p1_v) begin
      w_drive     = 1'b1;
      w_from_pend = 1'b1;
      w_last      = (r_p1_bl == 2'd0);
      w_state_nx  = w_last ? RD_IDLE : RD_BURST;
    end else if (r_state == RD_BURST) begin
      w_drive    = 1'b1;
      w_last     = (r_b_idx == w_b_last_idx);
      w_state_nx = w_last ? RD_IDLE : RD_BURST;
    end
  end

  // Burst engine state register.
  always_ff @(posedge clk_96 or posedge init) begin
    if (init) r_state <= RD_IDLE;
    else      r_state <= w_state_nx;
  end

  // Word array write with per-byte masks; contents survive reset.
  always_ff @(posedge clk_96) begin
    if (w_wr_ok) begin
      if (!sd_dqm[0]) r_mem[w_wr_addr][7:0]  <= sd_dq_in[7:0];
      if (!sd_dqm[1]) r_mem[w_wr_addr][15:8] <= sd_dq_in[15:8];
    end
  end

  // Registered read data and output enable.
  always_ff @(posedge clk_96 or posedge init) begin
    if (init) begin
      r_dq <= 16'd0;
      r_oe <= 1'b0;
    end else if (w_drive) begin
      r_dq <= r_mem[w_rd_addr];
      r_oe <= 1'b1;
    end else begin
      r_oe <= 1'b0;
    end
  end

  // Read pipeline: queue reads for CL-1 edges, then track the live burst.
  always_ff @(posedge clk_96 or posedge init) begin
    if (init) begin
      r_p1_v <= 1'b0; r_p1_addr <= '0; r_p1_bl <= '0; r_p1_ilv <= 1'b0; r_p1_ap <= 1'b0;
      r_p2_v <= 1'b0; r_p2_addr <= '0; r_p2_bl <= '0; r_p2_ilv <= 1'b0; r_p2_ap <= 1'b0;
      r_b_addr <= '0; r_b_bl <= '0; r_b_ilv <= 1'b0; r_b_ap <= 1'b0; r_b_idx <= '0;
    end else begin
      r_p1_v    <= r_p2_v;
      r_p1_addr <= r_p2_addr;
      r_p1_bl   <= r_p2_bl;
      r_p1_ilv  <= r_p2_ilv;
      r_p1_ap   <= r_p2_ap;
      r_p2_v    <= 1'b0;
      if (w_rd_ok) begin
        if (!r_cl3) begin
          r_p1_v <= 1'b1; r_p1_addr <= w_cmd_addr; r_p1_bl <= r_bl;
          r_p1_ilv <= r_ilv; r_p1_ap <= sd_addr[10];
        end else begin
          r_p2_v <= 1'b1; r_p2_addr <= w_cmd_addr; r_p2_bl <= r_bl;
          r_p2_ilv <= r_ilv; r_p2_ap <= sd_addr[10];
        end
      end
      if (w_kill) begin
        r_p1_v <= 1'b0;
        r_p2_v <= 1'b0;
      end
      if (w_drive) begin
        if (w_from_pend) begin
          r_b_addr <= r_p1_addr; r_b_bl <= r_p1_bl; r_b_ilv <= r_p1_ilv;
          r_b_ap <= r_p1_ap; r_b_idx <= 3'd1;
        end else begin
          r_b_idx <= r_b_idx + 3'd1;
        end
      end
    end
  end

  // Bank, mode and error bookkeeping.
  always_ff @(posedge clk_96 or posedge init) begin
    if (init) begin
      r_open <= 4'b0;
      for (int b = 0; b < 4; b++) begin
        r_row[b] <= '0;
        r_rcd[b] <= '0;
      end
      r_cl3  <= 1'b0;
      r_bl   <= 2'd0;
      r_ilv  <= 1'b0;
      r_err  <= 1'b0;
      r_code <= 3'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_rcd[b] != '0) r_rcd[b] <= r_rcd[b] - RCW'(1);
      end
      // Auto-precharge of a read lands on its last data edge.
      if (w_drive && w_last && w_sel_ap) r_open[w_sel_addr[23:22]] <= 1'b0;
      if (w_is_act) begin
        r_open[sd_ba] <= 1'b1;
        r_row[sd_ba]  <= sd_addr;
        r_rcd[sd_ba]  <= RCD_LOAD;
      end
      if (w_wr_ok && sd_addr[10]) r_open[sd_ba] <= 1'b0;
      if (w_is_pre) begin
        if (sd_addr[10]) r_open <= 4'b0;
        else             r_open[sd_ba] <= 1'b0;
      end
      if (w_is_lmr) begin
        r_ilv <= sd_addr[3];
        if (w_mode_bad) begin
          r_cl3 <= 1'b0;
          r_bl  <= 2'd0;
        end else begin
          r_cl3 <= sd_addr[4];
          r_bl  <= sd_addr[1:0];
        end
      end
      if (!r_err && (w_err != 3'd0)) begin
        r_err  <= 1'b1;
        r_code <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed command sequences, an edge-indexed
// expectation model of read data / oe / error flags checked every cycle,
// and hand-computed literal checks at key points.
module tb_sdram_responder;
  localparam int MEM_AW = 14;
  localparam int T_RCD  = 2;
  localparam int NE     = 1024;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                         C_WR  = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                         C_LMR = 4'b0000, C_BST = 4'b0110;

  logic        clk_96 = 1'b0;
  logic        init = 1'b1;
  logic        sd_cs = 1'b0, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
  logic [1:0]  sd_ba = 2'd0;
  logic [12:0] sd_addr = 13'd0;
  logic [1:0]  sd_dqm = 2'd0;
  logic [15:0] sd_dq_in = 16'd0;
  logic [15:0] sd_dq_out;
  logic        sd_dq_oe, proto_err;
  logic [2:0]  err_code;

  sdram_responder #(.MEM_AW(MEM_AW), .T_RCD(T_RCD)) dut (
    .clk_96(clk_96), .init(init), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas),
    .sd_we(sd_we), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm),
    .sd_dq_in(sd_dq_in), .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe),
    .proto_err(proto_err), .err_code(err_code));

  // Free-running clock.
  always #5 clk_96 = ~clk_96;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  bit run = 1'b0;

  // Model state.
  bit          exp_oe [0:NE-1];
  logic [15:0] exp_dq [0:NE-1];
  logic [15:0] m_mem  [0:(1<<MEM_AW)-1];
  bit          m_open [4];
  int          m_row [4], m_act [4], m_close [4];
  int          m_cl, m_bl, m_ilv, m_err, m_code;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Edge counter; edge k is the k-th rising edge.
  always @(posedge clk_96) cyc++;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk_96) begin
    if (run) begin
      check("oe", int'(sd_dq_oe), int'(exp_oe[cyc]));
      if (exp_oe[cyc]) check("dq", int'(sd_dq_out), int'(exp_dq[cyc]));
      check("proto_err", int'(proto_err), m_err);
      check("err_code", int'(err_code), m_code);
    end
  end

  function automatic int waddr(input int ba, input int row, input int col);
    return ((ba << 22) + row * 512 + col) % (1 << MEM_AW);
  endfunction

  // Drop scheduled read words and pending auto-precharges from edge e on.
  task automatic clear_from(input int e);
    for (int k = e; k < NE && k < e + 24; k++) exp_oe[k] = 1'b0;
    for (int b = 0; b < 4; b++) if (m_close[b] >= e) m_close[b] = -1;
  endtask

  task automatic model_reset();
    for (int k = cyc; k < NE; k++) exp_oe[k] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_open[b] = 1'b0; m_row[b] = 0; m_act[b] = -100; m_close[b] = -1;
    end
    m_cl = 2; m_bl = 1; m_ilv = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_apply(input int n, input logic [3:0] c, input int ba,
                             input logic [12:0] a, input logic [1:0] dqm, input logic [15:0] d);
    int code, any_open, was_open, col, f, off, ad;
    logic [15:0] old;
    code = 0;
    any_open = int'(m_open[0] | m_open[1] | m_open[2] | m_open[3]);
    was_open = int'(m_open[ba]);
    case (c)
      C_ACT: if (was_open != 0) code = 1;
      C_RD, C_WR: if (was_open == 0) code = 2; else if (n - m_act[ba] < T_RCD) code = 3;
      C_LMR: if (any_open != 0) code = 4;
             else if (!((a[6:4] == 3'd2) || (a[6:4] == 3'd3)) || a[2:0] > 3'd3) code = 5;
      C_REF: if (any_open != 0) code = 4;
      default: ;
    endcase
    if (m_err == 0 && code != 0) begin m_err = 1; m_code = code; end
    for (int b = 0; b < 4; b++) if (m_close[b] == n) begin m_open[b] = 1'b0; m_close[b] = -1; end
    case (c)
      C_ACT: begin m_open[ba] = 1'b1; m_row[ba] = int'(a); m_act[ba] = n; end
      C_RD: if (was_open != 0) begin
        col = int'(a[8:0]);
        f = n + m_cl - 1;
        clear_from(f);
        for (int i = 0; i < m_bl; i++) begin
          off = (m_ilv != 0) ? ((col % m_bl) ^ i) : ((col + i) % m_bl);
          exp_oe[f + i] = 1'b1;
          exp_dq[f + i] = m_mem[waddr(ba, m_row[ba], col - (col % m_bl) + off)];
        end
        if (a[10]) m_close[ba] = f + m_bl - 1;
      end
      C_WR: if (was_open != 0) begin
        ad = waddr(ba, m_row[ba], int'(a[8:0]));
        old = m_mem[ad];
        m_mem[ad] = {dqm[1] ? old[15:8] : d[15:8], dqm[0] ? old[7:0] : d[7:0]};
        clear_from(n);
        if (a[10]) m_open[ba] = 1'b0;
      end
      C_PRE: if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 1'b0; else m_open[ba] = 1'b0;
      C_BST: clear_from(n);
      C_LMR: begin
        m_ilv = int'(a[3]);
        if (code == 5 || !((a[6:4] == 3'd2) || (a[6:4] == 3'd3)) || a[2]) begin
          m_cl = 2; m_bl = 1;
        end else begin
          m_cl = int'(a[6:4]); m_bl = 1 << a[1:0];
        end
      end
      default: ;
    endcase
  endtask

  // One command per edge; called just after an edge, returns just after the next.
  task automatic step(input logic [3:0] c, input logic [1:0] ba = 2'd0,
                      input logic [12:0] a = 13'd0, input logic [1:0] dqm = 2'd0,
                      input logic [15:0] d = 16'd0);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba = ba; sd_addr = a; sd_dqm = dqm; sd_dq_in = d;
    @(posedge clk_96);
    #1;
    model_apply(cyc, c, int'(ba), a, dqm, d);
    {sd_cs, sd_ras, sd_cas, sd_we} = C_NOP;
  endtask

  task automatic nops(input int k);
    for (int i = 0; i < k; i++) step(C_NOP);
  endtask

  task automatic reset_pulse();
    init = 1'b1;
    model_reset();
    #1;
    check("async_oe_drop", int'(sd_dq_oe), 0);
    @(posedge clk_96);
    #1;
    init = 1'b0;
  endtask

  int ilv_order [8] = '{5, 4, 7, 6, 1, 0, 3, 2};
  int seq1 [4] = '{16'hA002, 16'hA003, 16'hA000, 16'hA001};

  initial begin
    for (int k = 0; k < NE; k++) begin exp_oe[k] = 1'b0; exp_dq[k] = 16'd0; end
    for (int k = 0; k < (1 << MEM_AW); k++) m_mem[k] = 16'd0;
    @(posedge clk_96);
    #1;
    reset_pulse();
    run = 1'b1;
    check("rst_dq", int'(sd_dq_out), 0);
    check("rst_oe", int'(sd_dq_oe), 0);
    check("rst_err", int'(proto_err), 0);
    check("rst_code", int'(err_code), 0);

    // Basic write/read: CL2 BL4 sequential, READ col 6 with auto-precharge.
    step(C_LMR, 2'd0, 13'h222);
    step(C_ACT, 2'd1, 13'd5);
    step(C_NOP);
    for (int c = 4; c < 8; c++) step(C_WR, 2'd1, 13'(c), 2'b00, 16'hA000 + 16'(c - 4));
    step(C_RD, 2'd1, 13'h406);
    check("t1_oe_n", int'(sd_dq_oe), 0);
    for (int i = 0; i < 4; i++) begin
      step(C_NOP);
      check("t1_oe", int'(sd_dq_oe), 1);
      check("t1_dq", int'(sd_dq_out), seq1[i]);
    end
    step(C_ACT, 2'd1, 13'd5);
    check("t1_oe_end", int'(sd_dq_oe), 0);
    check("t1_ap_err", int'(proto_err), 0);

    // Byte masking.
    step(C_NOP);
    for (int c = 9; c < 12; c++) step(C_WR, 2'd1, 13'(c), 2'b00, 16'hC000 + 16'(c));
    step(C_WR, 2'd1, 13'd8, 2'b00, 16'h1234);
    step(C_WR, 2'd1, 13'd8, 2'b10, 16'hFFFF);
    step(C_RD, 2'd1, 13'd8);
    step(C_NOP);
    check("t2_mask", int'(sd_dq_out), 16'h12FF);
    nops(4);

    // CL3 BL8 interleaved.
    step(C_PRE, 2'd0, 13'h400);
    step(C_LMR, 2'd0, 13'h03B);
    step(C_ACT, 2'd1, 13'd5);
    step(C_NOP);
    for (int c = 0; c < 8; c++) step(C_WR, 2'd1, 13'(c), 2'b00, 16'hB000 + 16'(c));
    step(C_RD, 2'd1, 13'd5);
    step(C_NOP);
    check("t3_oe_lat", int'(sd_dq_oe), 0);
    for (int i = 0; i < 8; i++) begin
      step(C_NOP);
      check("t3_dq", int'(sd_dq_out), 16'hB000 + ilv_order[i]);
    end
    step(C_NOP);
    check("t3_oe_end", int'(sd_dq_oe), 0);

    // Truncation by a second READ, then by BURST_TERMINATE.
    step(C_PRE, 2'd0, 13'h400);
    step(C_LMR, 2'd0, 13'h222);
    step(C_ACT, 2'd1, 13'd5);
    step(C_NOP);
    step(C_RD, 2'd1, 13'd0);
    step(C_NOP);
    step(C_RD, 2'd1, 13'd8);
    check("t4a_first2", int'(sd_dq_out), 16'hB001);
    step(C_NOP);
    check("t4a_second", int'(sd_dq_out), 16'h12FF);
    nops(3);
    step(C_NOP);
    check("t4a_end", int'(sd_dq_oe), 0);
    step(C_RD, 2'd1, 13'd0);
    nops(2);
    step(C_BST);
    check("t4b_bst", int'(sd_dq_oe), 0);
    step(C_NOP);

    // Reset in the middle of a burst.
    step(C_RD, 2'd1, 13'd0);
    step(C_NOP);
    check("mid_oe", int'(sd_dq_oe), 1);
    reset_pulse();

    // Errors: first code sticks until init.
    step(C_RD, 2'd2, 13'd0);
    check("t5_err", int'(proto_err), 1);
    step(C_ACT, 2'd0, 13'd0);
    step(C_ACT, 2'd0, 13'd0);
    check("t5_code", int'(err_code), 2);
    reset_pulse();
    check("t5_clr_err", int'(proto_err), 0);
    check("t5_clr_code", int'(err_code), 0);

    // tRCD violation.
    step(C_ACT, 2'd1, 13'd5);
    step(C_RD, 2'd1, 13'd0);
    step(C_NOP);
    check("t6a_code", int'(err_code), 3);
    reset_pulse();

    // Refresh with a bank open.
    step(C_ACT, 2'd0, 13'd0);
    step(C_REF);
    check("t6b_code", int'(err_code), 4);
    reset_pulse();

    // Illegal mode: flagged, falls back to CL2 BL1.
    step(C_LMR, 2'd0, 13'h252);
    check("bad_mode_code", int'(err_code), 5);
    step(C_ACT, 2'd1, 13'd5);
    step(C_NOP);
    step(C_RD, 2'd1, 13'd3);
    step(C_NOP);
    check("bad_mode_dq", int'(sd_dq_out), 16'hB003);
    step(C_NOP);
    check("bad_mode_bl1", int'(sd_dq_oe), 0);
    nops(2);

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device responder: the chip-side end of the MT48LC16M16-style command interface that the `sdram` controller drives. It decodes CS/RAS/CAS/WE commands, tracks the mode register and per-bank open rows, and serves reads and writes from an internal block-RAM array. It replaces the external chip for FPGA targets without SDRAM and serves as the protocol checker in controller regression benches.

## Interface

Parameters:
- `MEM_AW`, 14: word-address width of the internal array (2^MEM_AW x 16 bit).
- `T_RCD`, 2: minimum clock edges from ACTIVE to READ/WRITE on the same bank.

Ports:
- `clk_96` in 1: the single clock; all commands are sampled on its rising edge.
- `init` in 1: reset, asynchronous, active-high.
- `sd_cs`, `sd_ras`, `sd_cas`, `sd_we` in 1 each: command `{cs,ras,cas,we}`.
- `sd_ba` in 2: bank.
- `sd_addr` in 13: row, column, or mode value.
- `sd_dqm` in 2: write byte masks; bit1 masks the upper byte.
- `sd_dq_in` in 16: write data.
- `sd_dq_out` out 16: read data.
- `sd_dq_oe` out 1: high while `sd_dq_out` carries valid read data.
- `proto_err` out 1: sticky protocol-violation flag.
- `err_code` out 3: code of the first violation.

## Operation

- **Command decode** (`{cs,ras,cas,we}`):
  - 1xxx INHIBIT and 0111 NOP do nothing.
  - 0011 ACTIVE opens `sd_addr` as the row in `sd_ba`.
  - 0101 READ and 0100 WRITE use column `{sd_addr[8:0]}`; `sd_addr[10]` requests auto-precharge.
  - 0010 PRECHARGE closes all banks if `sd_addr[10]` is set, else closes `sd_ba`.
  - 0001 AUTO_REFRESH is a NOP.
  - 0000 LOAD_MODE sets CL from `sd_addr[6:4]`, burst type from `sd_addr[3]` (1 = interleaved), and BL from `sd_addr[2:0]` (000 = 1, 001 = 2, 010 = 4, 011 = 8).
  - 0110 BURST_TERMINATE stops the active read burst.
- **Array address**: `{sd_ba, row, col}` truncated to the low `MEM_AW` bits. Aliasing above that is accepted.
- **Writes**:
  - Always single-word, regardless of `sd_addr[9]`.
  - Data and DQM are sampled with the WRITE command.
  - A masked byte is left unchanged.
- **Read burst order**, word i = 0..BL-1:
  - Sequential: `col[8:3..]` kept, and the low log2(BL) bits are `(col + i) mod BL`.
  - Interleaved: the low bits are `col XOR i`.
  - DQM is ignored on reads.
- **Bank state**:
  - Each of 4 banks is either idle or open with a row.
  - Auto-precharge on WRITE closes the bank at the command edge.
  - Auto-precharge on READ closes the bank at the last data edge.
- **Burst interruption**:
  - A new READ replaces the active burst when its first word becomes due.
  - WRITE or BURST_TERMINATE cancels any active or pending read at that edge.
  - PRECHARGE does not truncate a burst.
- **Errors**: `proto_err` is set on the first violation and `err_code` latches that violation's code. Later violations do not change either output. Only `init` clears them. Codes:
  - 1: ACTIVE to an open bank.
  - 2: READ/WRITE to an idle bank.
  - 3: READ/WRITE fewer than `T_RCD` edges after ACTIVE on that bank.
  - 4: LOAD_MODE or AUTO_REFRESH with any bank open.
  - 5: LOAD_MODE with CL not 2/3 or BL > 011. Mode is still loaded; CL is forced to 2 and BL to 1.
- **Reset values**:
  - Outputs: `sd_dq_out`=0, `sd_dq_oe`=0, `proto_err`=0, `err_code`=0.
  - State: all banks idle, CL=2, BL=1, sequential, no pending read.
  - Array contents are not reset.
  - `init` asserted mid-burst drops `sd_dq_oe` immediately (asynchronous).

## Timing

- READ sampled at edge N: word i is driven (registered) at edge N+CL-1+i, valid for sampling at edge N+CL+i. `sd_dq_oe` is high from edge N+CL-1 through edge N+CL+BL-2.
- WRITE sampled at edge N: the array is updated at edge N. A READ at edge N+1 of the same word returns the new data.
- ACTIVE at edge A: READ/WRITE is legal at edge ≥ A+`T_RCD`.
- Auto-precharged read: ACTIVE to the same bank is legal at edge ≥ N+CL+BL-1.
- Read-data latency is fixed. There are no wait states or handshakes.

## Test plan

1. **Basic write/read**:
   - Stimulus: pulse `init`; LOAD_MODE 0x222 (CL2, BL4, sequential); ACTIVE ba=1 row=5; WRITE cols 4..7 with 0xA000..0xA003 (dqm=00); READ col 6 with auto-precharge.
   - Required response: words 0xA002, 0xA003, 0xA000, 0xA001 at edges N+2..N+5; oe high exactly for edges N+1..N+4; `proto_err`=0.
2. **Byte masking**:
   - Stimulus: WRITE 0x1234, then WRITE 0xFFFF with dqm=2'b10 to the same word, then read it back.
   - Required response: read returns 0x12FF.
3. **CL3, BL8 interleaved**:
   - Stimulus: mode 0x03B; READ col 5.
   - Required response: order 5,4,7,6,1,0,3,2 starting valid at edge N+3.
4. **Truncation**:
   - Stimulus (a): BL4 READ at N, second READ at N+2.
   - Required response (a): 2 words of the first burst, then 4 of the second.
   - Stimulus (b): BURST_TERMINATE at N+3.
   - Required response (b): oe low from edge N+3.
5. **Errors**:
   - Stimulus: READ to an idle bank, then ACTIVE twice to the same bank.
   - Required response: `proto_err`=1 and `err_code`=2 (unchanged by the second error); `init` clears both to 0.
6. **tRCD and refresh violations**:
   - Stimulus (a): READ 1 edge after ACTIVE.
   - Required response (a): `err_code`=3.
   - Stimulus (b): fresh reset, then AUTO_REFRESH with bank 0 open.
   - Required response (b): `err_code`=4.
